// File: rtl/bmf_pkg.sv
// Shared types and defaults for the BMF h-side decoder.
// Holds the semiring select and the power-on basis pattern.
package bmf_pkg;

  localparam int K_DEF = 5;
  localparam int M_DEF = 6;
  localparam int MAX_M = 32;

  typedef enum logic {
    SR_OR  = 1'b0,
    SR_XOR = 1'b1
  } semiring_e;

  // Row r drives output bit r+1, so po[0] stays 0 and po[r+1] mirrors k[r].
  function automatic logic [MAX_M-1:0] h_reset_row(input int r, input int m);
    logic [MAX_M-1:0] row;
    row = '0;
    if (r + 1 < m) row[r+1] = 1'b1;
    return row;
  endfunction

endpackage

// File: rtl/bmf_bool_product.sv
// Combinational Boolean product po = k x H over OR/AND or XOR/AND.
// Zero latency, no flow control.
module bmf_bool_product
  import bmf_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = M_DEF
) (
  input  logic [K-1:0]   k,
  input  logic [K*M-1:0] h,
  input  semiring_e      mode,
  output logic [M-1:0]   po
);

  always_comb begin
    po = '0;
    for (int r = 0; r < K; r++) begin
      if (k[r]) begin
        if (mode == SR_XOR) po = po ^ h[r*M +: M];
        else                po = po | h[r*M +: M];
      end
    end
  end

endmodule

// File: rtl/bmf_h_decoder.sv
// Programmable-basis BMF decoder: one registered stage, 1-cycle latency.
// in_ready passes out_ready through when the output register is full; no skid buffer.
module bmf_h_decoder
  import bmf_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int M     = M_DEF,
  parameter int CNT_W = 16,
  localparam int RW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [RW-1:0]    cfg_row,
  input  logic [M-1:0]     cfg_data,
  input  logic             cfg_xor,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_po,
  output logic [CNT_W-1:0] dec_count
);

  logic [K*M-1:0]   h_q;
  logic [K*M-1:0]   h_rst;
  semiring_e        mode_q;
  logic [M-1:0]     dec_po;
  logic             row_hit;
  logic             accept;
  logic             deliver;

  for (genvar r = 0; r < K; r++) begin : g_rst
    localparam logic [MAX_M-1:0] RST_ROW = h_reset_row(r, M);
    assign h_rst[r*M +: M] = RST_ROW[M-1:0];
  end

  assign row_hit = cfg_we && (32'(cfg_row) < K);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  bmf_bool_product #(
    .K (K),
    .M (M)
  ) u_product (
    .k    (in_k),
    .h    (h_q),
    .mode (mode_q),
    .po   (dec_po)
  );

  // Config updates land on the same edge as an accept, so the accepted word sees the old basis.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= h_rst;
      mode_q <= SR_OR;
    end else if (row_hit) begin
      h_q[32'(cfg_row)*M +: M] <= cfg_data;
      mode_q                   <= semiring_e'(cfg_xor);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_po    <= '0;
      dec_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_po    <= dec_po;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (deliver && (dec_count != '1)) dec_count <= dec_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bmf_h_decoder.sv
// Bench for bmf_h_decoder: directed tables, corner sequences and random traffic vs a column-wise model.
module tb_bmf_h_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_row;
  logic [5:0] cfg_data;
  logic       cfg_xor;
  logic       in_valid;
  logic [4:0] in_k;
  logic       out_ready;

  logic       in_ready, in_ready_s;
  logic       out_valid, out_valid_s;
  logic [5:0] out_po, out_po_s;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  bmf_h_decoder #(.K(5), .M(6), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_xor(cfg_xor), .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready), .out_po(out_po), .dec_count(cnt16)
  );

  bmf_h_decoder #(.K(5), .M(6), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_xor(cfg_xor), .in_valid(in_valid), .in_ready(in_ready_s), .in_k(in_k),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_po(out_po_s), .dec_count(cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [5:0] m_h [5];
  logic       m_xor;
  logic       m_vld;
  logic [5:0] m_po;
  int         m_cnt;

  typedef struct {
    logic [4:0] k;
    logic [5:0] po;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each output bit counts the active rows that have that column set.
  function automatic logic [5:0] ref_decode(input logic [4:0] k);
    logic [5:0] po;
    for (int c = 0; c < 6; c++) begin
      int ones;
      ones = 0;
      for (int r = 0; r < 5; r++)
        if (k[r] && m_h[r][c]) ones++;
      po[c] = m_xor ? (ones % 2 == 1) : (ones > 0);
    end
    return po;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 5; r++) m_h[r] = (r + 1 < 6) ? 6'(1 << (r + 1)) : 6'd0;
    m_xor = 1'b0;
    m_vld = 1'b0;
    m_po  = '0;
    m_cnt = 0;
  endtask

  task automatic cyc();
    logic       acc, dlv;
    logic [5:0] dpo;
    #1;
    chk("in_ready", in_ready, !m_vld || out_ready);
    chk("in_ready_sat", in_ready_s, !m_vld || out_ready);
    acc = in_valid && (!m_vld || out_ready);
    dlv = m_vld && out_ready;
    dpo = ref_decode(in_k);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        m_po  = dpo;
        m_vld = 1'b1;
      end else if (dlv) begin
        m_vld = 1'b0;
      end
      if (dlv) m_cnt++;
      if (cfg_we && cfg_row < 3'd5) begin
        m_h[cfg_row] = cfg_data;
        m_xor        = cfg_xor;
      end
    end
    #1;
    chk("out_valid", out_valid, m_vld);
    chk("out_po", out_po, m_po);
    chk("dec_count", cnt16, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("dec_count_sat", cnt4, (m_cnt > 15) ? 15 : m_cnt);
  endtask

  task automatic idle();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [6];
    int   c0;

    tbl[0] = '{5'b10110, 6'b101100};
    tbl[1] = '{5'b00001, 6'b000010};
    tbl[2] = '{5'b11111, 6'b111110};
    tbl[3] = '{5'b10000, 6'b100000};
    tbl[4] = '{5'b00000, 6'b000000};
    tbl[5] = '{5'b01010, 6'b010100};

    rst = 1'b1; cfg_we = 0; cfg_row = 0; cfg_data = 0; cfg_xor = 0;
    in_valid = 0; in_k = 0; out_ready = 1;
    model_reset();
    @(posedge clk);
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_po", out_po, 0);
    chk("rst_dec_count", cnt16, 0);
    rst = 1'b0;

    // Default basis, streamed back to back
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_k = tbl[i].k; out_ready = 1;
      cyc();
      chk("default_tbl", out_po, tbl[i].po);
    end
    idle(); cyc();

    // OR vs XOR
    cfg_we = 1; cfg_row = 0; cfg_data = 6'b000011; cfg_xor = 0; cyc();
    cfg_row = 1; cfg_data = 6'b000001; cyc();
    cfg_we = 0; in_valid = 1; in_k = 5'b00011; cyc();
    chk("or_mode", out_po, 6'b000011);
    in_valid = 0; cfg_we = 1; cfg_row = 1; cfg_data = 6'b000001; cfg_xor = 1; cyc();
    cfg_we = 0; in_valid = 1; in_k = 5'b00011; cyc();
    chk("xor_mode", out_po, 6'b000010);
    idle(); cyc();

    // Back-pressure
    in_valid = 1; in_k = 5'b00100; out_ready = 0; cyc();
    c0 = m_cnt;
    in_k = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_po", out_po, 6'b001000);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cnt", cnt16, c0);
    end
    in_valid = 0; out_ready = 1; cyc();
    chk("bp_release_cnt", cnt16, c0 + 1);
    chk("bp_release_vld", out_valid, 0);

    // Same-cycle cfg write and accept, from defaults
    rst = 1; cyc(); rst = 0;
    cfg_we = 1; cfg_row = 0; cfg_data = 6'b111111; cfg_xor = 0;
    in_valid = 1; in_k = 5'b00001; cyc();
    chk("cfg_acc_old", out_po, 6'b000010);
    cfg_we = 0; cyc();
    chk("cfg_acc_new", out_po, 6'b111111);
    idle(); cyc();

    // Out-of-range row is ignored
    rst = 1; cyc(); rst = 0;
    cfg_we = 1; cfg_row = 3'd5; cfg_data = 6'b111111; cfg_xor = 1; cyc();
    cfg_row = 3'd7; cyc();
    cfg_we = 0; in_valid = 1; in_k = 5'b11111; cyc();
    chk("oor_row", out_po, 6'b111110);

    // Reset mid-stream with a pending word and a modified basis
    in_valid = 1; in_k = 5'b00001; cyc();
    cfg_we = 1; cfg_row = 0; cfg_data = 6'b111111; cfg_xor = 0;
    in_k = 5'b00010; out_ready = 0; cyc();
    idle(); cyc();
    rst = 1; cyc(); rst = 0;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_cnt", cnt16, 0);
    out_ready = 1; in_valid = 1; in_k = 5'b00001; cyc();
    chk("midrst_default", out_po, 6'b000010);
    idle(); cyc();

    // Saturation
    rst = 1; cyc(); rst = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_k = 5'($urandom);
      cyc();
    end
    idle(); cyc();
    chk("sat_cnt4", cnt4, 15);
    chk("sat_cnt16", cnt16, 20);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_row   = 3'($urandom_range(0, 7));
      cfg_data  = 6'($urandom);
      cfg_xor   = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_k      = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 0; idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bmf_h_decoder.md
# bmf_h_decoder

Streaming decoder for Boolean-matrix-factorized (BMF) approximate circuits. It takes a K-bit latent vector and reconstructs the M-bit primary-output word as a Boolean product with a programmable basis matrix H (K rows × M columns). The basis is loaded through a row-write port. The block sits downstream of a compressor stage and is the runtime-reconfigurable counterpart of a fixed h-side mapping, so one netlist can evaluate many factorization candidates. Output is a single registered pipeline stage with valid/ready flow control and a saturating count of decoded words.

## Interface
- K, 5, latent width (number of H rows), 1..16
- M, 6, output width (number of H columns), 1..32
- CNT_W, 16, width of decoded-word counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  H row write strobe
- cfg_row  in  $clog2(K) (min 1)  row index; writes with index ≥ K are ignored
- cfg_data  in  M  row contents
- cfg_xor  in  1  semiring select, sampled when cfg_we=1: 0 = OR/AND, 1 = XOR/AND (GF(2))
- in_valid  in  1  latent vector valid
- in_ready  out  1  decoder can accept
- in_k  in  K  latent vector
- out_valid  out  1  out_po valid
- out_ready  in  1  consumer accepts
- out_po  out  M  reconstructed output word
- dec_count  out  CNT_W  number of words delivered, saturating

## Operation
- H storage: K registers of M bits, plus a 1-bit mode register.
- Reset values:
  - H row r = 1 << (r+1) when r+1 < M, otherwise 0. This gives po0 = 0 and po[r+1] = k[r].
  - mode = OR.
  - out_valid = 0, out_po = 0, dec_count = 0.
- Config write: when cfg_we=1 and cfg_row < K, H[cfg_row] ← cfg_data and mode ← cfg_xor, both at the next edge.
- Decode function:
  - OR mode: out_po = OR over r of (in_k[r] ? H[r] : 0).
  - XOR mode: the same with XOR in place of OR.
  - in_k = 0 yields 0 in both modes.
- Accept: in_valid && in_ready. On an accept, out_po is loaded with the decode of in_k, using H and mode as they stand *before* that edge, and out_valid ← 1.
- Deliver: out_valid && out_ready.
  - If there is no simultaneous accept: out_valid ← 0 and out_po holds its last value.
  - On every deliver, dec_count increments unless it is already all-ones.
- in_ready = !out_valid || out_ready (combinational pass-through of ready; no skid buffer).
- Stall: while out_valid=1 and out_ready=0, out_po and out_valid stay stable.
- Config writes are legal at any time. They never alter a word already in the output register.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous cfg write and accept in the same cycle: the accepted word uses the old H/mode. The next accepted word uses the new values.
- Simultaneous deliver and accept: out_valid stays 1, out_po is replaced by the new word, and dec_count increments once.
- Two writes to the same row in consecutive cycles: the last one wins.
- Reset mid-stream: at the reset edge the in-flight word is dropped, H and mode return to their defaults, and dec_count returns to 0. in_ready is 1 in the first cycle after reset.
- dec_count saturates at 2^CNT_W−1 and does not wrap.

## Structure
- Package bmf_pkg holds:
  - default K and M localparams,
  - the semiring enum (SR_OR, SR_XOR),
  - a function returning the reset row value for an index r.
- Sub-module bmf_bool_product: purely combinational, inputs (k, H flattened K·M, mode), output M bits. It holds the OR/XOR reduction.
- The top level holds:
  - the H register file,
  - the mode register,
  - the output pipeline register with its handshake,
  - the counter.

## Test plan
- **Reset default (K=5, M=6):** after reset, stream in_k=5'b10110 with out_ready=1 → out_po=6'b101100 one cycle after accept; in_k=5'b00001 → 6'b000010.
- **OR vs XOR:**
  - Setup: write H[0]=6'b000011, H[1]=6'b000001.
  - With cfg_xor=0, in_k=5'b00011 → 6'b000011.
  - Rewrite H[1]=6'b000001 with cfg_xor=1, then in_k=5'b00011 → 6'b000010.
- **Back-pressure:**
  - Accept in_k=5'b00100, then hold out_ready=0 for 3 cycles.
  - Required: out_po=6'b001000 stable, in_ready=0, and dec_count unchanged until out_ready=1.
  - dec_count then increments by 1.
- **Same-cycle cfg write and accept:** write H[0]=6'b111111 in the same cycle as accepting in_k=5'b00001 → out_po=6'b000010. The next in_k=5'b00001 → 6'b111111.
- **Out-of-range row and reset mid-stream:**
  - cfg_row=5 with K=5 → no H change.
  - Assert rst while out_valid=1 → out_valid=0 next cycle, dec_count=0, and the H defaults are restored.
- **Saturation:** with CNT_W=4, deliver 20 words → dec_count=15.
